fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined CPU.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word into the IF/ID register. The decode stage takes the opcode (if_instr[15:12]) from that register and feeds it to the control decoder.
- Applies redirects for BR, JAL and JR, the single-instruction EXEC detour, and stall/flush requests from the hazard unit.

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the 16-bit CPU front end: widths, opcodes, bubble word
// and the fetch-stage FSM encoding.
package fetch_stage_pkg;

  localparam int WIDTH = 16;

  localparam logic [WIDTH-1:0] NOP_INSTR = 16'h0000;  // ADD R0,R0,R0

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_JR   = 4'hC;
  localparam logic [3:0] OP_EXEC = 4'hE;

  typedef enum logic {
    RUN      = 1'b0,
    EXEC_ONE = 1'b1
  } state_t;

  function automatic logic [3:0] opcode_of(input logic [WIDTH-1:0] instr);
    return instr[WIDTH-1:WIDTH-4];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {instruction, link value, valid} with bubble/load/hold.
// bubble wins over load; with neither asserted the contents hold.
module fetch_stage_if_id_reg #(
  parameter int               WIDTH     = fetch_stage_pkg::WIDTH,
  parameter logic [WIDTH-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic             load,
  input  logic [WIDTH-1:0] instr_d,
  input  logic [WIDTH-1:0] pc_plus1_d,
  output logic [WIDTH-1:0] instr_q,
  output logic [WIDTH-1:0] pc_plus1_q,
  output logic             valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (bubble) begin
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (load) begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, EXEC detour FSM and the IF/ID register.
// Per-edge priority: redirect, exec, stall, normal fetch.
module fetch_stage #(
  parameter int               WIDTH     = fetch_stage_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    redirect_valid,
  input  logic [WIDTH-1:0]        redirect_pc,
  input  logic                    exec_valid,
  input  logic [WIDTH-1:0]        exec_pc,
  input  logic [WIDTH-1:0]        exec_ret,
  output logic [WIDTH-1:0]        imem_addr,
  input  logic [WIDTH-1:0]        imem_rdata,
  output logic [WIDTH-1:0]        if_instr,
  output logic [WIDTH-1:0]        if_pc_plus1,
  output logic                    if_valid,
  output logic [WIDTH-1:0]        pc_out,
  output fetch_stage_pkg::state_t state_dbg
);

  import fetch_stage_pkg::state_t;
  import fetch_stage_pkg::RUN;
  import fetch_stage_pkg::EXEC_ONE;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0] tgt_reg, tgt_nxt;
  logic [WIDTH-1:0] ret_reg, ret_nxt;
  logic [WIDTH-1:0] link_val;
  logic             ifid_bubble, ifid_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pc      <= RESET_PC;
      tgt_reg <= '0;
      ret_reg <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      tgt_reg <= tgt_nxt;
      ret_reg <= ret_nxt;
    end
  end

  // In EXEC_ONE the detour instruction links to, and resumes at, the saved return address.
  assign link_val = (state == EXEC_ONE) ? ret_reg : pc + PC_STEP;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    tgt_nxt     = tgt_reg;
    ret_nxt     = ret_reg;
    ifid_bubble = 1'b0;
    ifid_load   = 1'b0;
    if (redirect_valid) begin
      pc_nxt      = redirect_pc;
      state_nxt   = RUN;
      ifid_bubble = 1'b1;
    end else if (exec_valid) begin
      tgt_nxt     = exec_pc;
      ret_nxt     = exec_ret;
      state_nxt   = EXEC_ONE;
      ifid_bubble = 1'b1;
    end else if (stall) begin
      ifid_bubble = flush;
    end else begin
      pc_nxt      = link_val;
      state_nxt   = RUN;
      ifid_bubble = flush;
      ifid_load   = ~flush;
    end
  end

  assign imem_addr = (state == EXEC_ONE) ? tgt_reg : pc;
  assign pc_out    = pc;
  assign state_dbg = state;

  fetch_stage_if_id_reg #(
    .WIDTH     (WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .bubble     (ifid_bubble),
    .load       (ifid_load),
    .instr_d    (imem_rdata),
    .pc_plus1_d (link_val),
    .instr_q    (if_instr),
    .pc_plus1_q (if_pc_plus1),
    .valid_q    (if_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns 16'h1000 + address.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall, flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        exec_valid;
  logic [15:0] exec_pc, exec_ret;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_instr, if_pc_plus1, pc_out;
  logic        if_valid;
  state_t      state_dbg;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exec_valid     (exec_valid),
    .exec_pc        (exec_pc),
    .exec_ret       (exec_ret),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_instr       (if_instr),
    .if_pc_plus1    (if_pc_plus1),
    .if_valid       (if_valid),
    .pc_out         (pc_out),
    .state_dbg      (state_dbg)
  );

  assign imem_rdata = 16'h1000 + imem_addr;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; redirect_valid = 0; exec_valid = 0;
    redirect_pc = '0; exec_pc = '0; exec_ret = '0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    rst = 1'b1;
    idle_inputs();
    step();
    total++; if (pc_out !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    total++; if (if_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", if_instr); end
    total++; if (if_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL reset_link got=%h exp=0000", if_pc_plus1); end
    rst = 1'b0;
    exp_q = {16'h1000, 16'h1001, 16'h1002};
    for (int k = 0; k < 3; k++) begin
      step();
      exp_w = exp_q.pop_front();
      total++; if (if_instr !== exp_w) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, if_instr, exp_w); end
      total++; if (if_pc_plus1 !== 16'(k + 1)) begin bad++; $display("FAIL seq_link[%0d] got=%h exp=%h", k, if_pc_plus1, 16'(k + 1)); end
      total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, if_valid); end
    end
  endtask

  task automatic test_stall();
    step(); step();  // fetch 1003, 1004; pc now 5
    total++; if (if_instr !== 16'h1004 || pc_out !== 16'h0005) begin bad++; $display("FAIL pre_stall instr=%h pc=%h exp 1004/0005", if_instr, pc_out); end
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (if_instr !== 16'h1004 || pc_out !== 16'h0005) begin bad++; $display("FAIL stall_hold[%0d] instr=%h pc=%h exp 1004/0005", k, if_instr, pc_out); end
    end
    stall = 0;
    step();
    total++; if (if_instr !== 16'h1005 || pc_out !== 16'h0006) begin bad++; $display("FAIL post_stall instr=%h pc=%h exp 1005/0006", if_instr, pc_out); end
  endtask

  task automatic test_redirect_over_stall();
    redirect_valid = 1; redirect_pc = 16'h0040; stall = 1;
    step();
    idle_inputs();
    total++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || pc_out !== 16'h0040) begin bad++; $display("FAIL redirect valid=%b instr=%h pc=%h exp 0/0000/0040", if_valid, if_instr, pc_out); end
    step();
    total++; if (if_instr !== 16'h1040 || if_pc_plus1 !== 16'h0041) begin bad++; $display("FAIL redirect_fetch instr=%h link=%h exp 1040/0041", if_instr, if_pc_plus1); end
  endtask

  task automatic test_exec();
    exec_valid = 1; exec_pc = 16'h0080; exec_ret = 16'h0011;
    step();
    idle_inputs();
    total++; if (if_valid !== 1'b0 || state_dbg !== EXEC_ONE || imem_addr !== 16'h0080) begin bad++; $display("FAIL exec_bubble valid=%b state=%b addr=%h exp 0/1/0080", if_valid, state_dbg, imem_addr); end
    step();
    total++; if (if_instr !== 16'h1080 || if_pc_plus1 !== 16'h0011 || if_valid !== 1'b1) begin bad++; $display("FAIL exec_target instr=%h link=%h valid=%b exp 1080/0011/1", if_instr, if_pc_plus1, if_valid); end
    step();
    total++; if (if_instr !== 16'h1011 || pc_out !== 16'h0012 || state_dbg !== RUN) begin bad++; $display("FAIL exec_return instr=%h pc=%h state=%b exp 1011/0012/0", if_instr, pc_out, state_dbg); end
  endtask

  task automatic test_exec_stall_redirect();
    exec_valid = 1; exec_pc = 16'h0080; exec_ret = 16'h0013;
    step();
    idle_inputs();
    stall = 1;
    step();
    stall = 0;
    total++; if (imem_addr !== 16'h0080 || state_dbg !== EXEC_ONE || if_valid !== 1'b0) begin bad++; $display("FAIL exec_stall addr=%h state=%b valid=%b exp 0080/1/0", imem_addr, state_dbg, if_valid); end
    step();
    total++; if (if_instr !== 16'h1080 || if_pc_plus1 !== 16'h0013 || pc_out !== 16'h0013) begin bad++; $display("FAIL exec_stall_done instr=%h link=%h pc=%h exp 1080/0013/0013", if_instr, if_pc_plus1, pc_out); end
    exec_valid = 1; exec_pc = 16'h0080; exec_ret = 16'h0014;
    step();
    idle_inputs();
    redirect_valid = 1; redirect_pc = 16'h0020;
    step();
    idle_inputs();
    total++; if (state_dbg !== RUN || pc_out !== 16'h0020 || if_valid !== 1'b0) begin bad++; $display("FAIL exec_redirect state=%b pc=%h valid=%b exp 0/0020/0", state_dbg, pc_out, if_valid); end
    step();
    total++; if (if_instr !== 16'h1020 || if_pc_plus1 !== 16'h0021 || pc_out !== 16'h0021) begin bad++; $display("FAIL exec_redirect_fetch instr=%h link=%h pc=%h exp 1020/0021/0021", if_instr, if_pc_plus1, pc_out); end
  endtask

  task automatic test_flush();
    flush = 1;
    step();
    flush = 0;
    total++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || pc_out !== 16'h0022) begin bad++; $display("FAIL flush valid=%b instr=%h pc=%h exp 0/0000/0022", if_valid, if_instr, pc_out); end
    step();
    total++; if (if_instr !== 16'h1022 || pc_out !== 16'h0023) begin bad++; $display("FAIL flush_next instr=%h pc=%h exp 1022/0023", if_instr, pc_out); end
    stall = 1; flush = 1;
    step();
    idle_inputs();
    total++; if (if_valid !== 1'b0 || pc_out !== 16'h0023) begin bad++; $display("FAIL stall_flush valid=%b pc=%h exp 0/0023", if_valid, pc_out); end
  endtask

  task automatic test_nested_exec();
    exec_valid = 1; exec_pc = 16'h0080; exec_ret = 16'h0030;
    step();
    exec_pc = 16'h0090; exec_ret = 16'h0050;
    step();
    idle_inputs();
    total++; if (state_dbg !== EXEC_ONE || imem_addr !== 16'h0090) begin bad++; $display("FAIL nested_exec state=%b addr=%h exp 1/0090", state_dbg, imem_addr); end
    step();
    total++; if (if_instr !== 16'h1090 || if_pc_plus1 !== 16'h0050 || pc_out !== 16'h0050) begin bad++; $display("FAIL nested_exec_done instr=%h link=%h pc=%h exp 1090/0050/0050", if_instr, if_pc_plus1, pc_out); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1; redirect_pc = 16'hFFFF;
    step();
    idle_inputs();
    step();
    total++; if (pc_out !== 16'h0000 || if_instr !== 16'h0FFF || if_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL pc_wrap pc=%h instr=%h link=%h exp 0000/0fff/0000", pc_out, if_instr, if_pc_plus1); end
  endtask

  task automatic test_async_reset();
    exec_valid = 1; exec_pc = 16'h0080; exec_ret = 16'h0077;
    step();
    idle_inputs();
    step();  // target word latched, back in RUN at 0x0077
    exec_valid = 1; exec_pc = 16'h0085; exec_ret = 16'h0066;
    step();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    total++; if (state_dbg !== RUN || pc_out !== 16'h0000 || imem_addr !== 16'h0000) begin bad++; $display("FAIL async_rst_state state=%b pc=%h addr=%h exp 0/0000/0000", state_dbg, pc_out, imem_addr); end
    total++; if (if_valid !== 1'b0 || if_instr !== 16'h0000 || if_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL async_rst_ifid valid=%b instr=%h link=%h exp 0/0000/0000", if_valid, if_instr, if_pc_plus1); end
    step();
    rst = 1'b0;
    step();
    total++; if (if_instr !== 16'h1000 || if_pc_plus1 !== 16'h0001 || pc_out !== 16'h0001) begin bad++; $display("FAIL post_rst instr=%h link=%h pc=%h exp 1000/0001/0001", if_instr, if_pc_plus1, pc_out); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_over_stall();
    test_exec();
    test_exec_stall_redirect();
    test_flush();
    test_nested_exec();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
